controle_multiciclo: RTL and testbench
======================================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 opcode  input  6  instruction bits [31:26] from instruction register.
REQ-004 funct  input  6  instruction bits [5:0] from instruction register.
REQ-005 Z  input  1  ULA zero flag (A-B==0), combinational from ULA.
REQ-006 O  input  1  ULA signed-overflow flag, combinational from ULA.
REQ-007 ULAopcode  output  4  ULA operation: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-008 ULAsrcA  output  1  0=PC, 1=register A.
REQ-009 ULAsrcB  output  2  00=reg B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2.
REQ-010 IorD, MemRead, MemWrite, IRwrite  output  1 each  memory address select (0=PC, 1=ALUOut) and memory/IR strobes.
REQ-011 RegDst, MemtoReg, RegWrite  output  1 each  rd/rt select, MDR/ALUOut select, register-file write.
REQ-012 PCwrite  output  1  PC load enable (unconditional or branch-qualified).
REQ-013 PCsrc  output  2  00=ULA R, 01=ALUOut, 10=jump target.
REQ-014 ovf_exc  output  1  one-cycle pulse: arithmetic overflow, writeback suppressed.
REQ-015 illegal  output  1  one-cycle pulse: unsupported opcode/funct.

Function
REQ-016 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP; one transition per clk.
REQ-017 FETCH: MemRead=1, IorD=0, IRwrite=1, ULAsrcA=0, ULAsrcB=01, ULAopcode=ADD, PCsrc=00, PCwrite=1; -> DECODE.
REQ-018 DECODE: ULAsrcA=0, ULAsrcB=11, ULAopcode=ADD (branch target into ALUOut); next by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->FETCH with illegal=1 that cycle.
REQ-019 EXEC: ULAsrcA=1, ULAsrcB=00, ULAopcode by funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT; other funct -> illegal=1, ULAopcode=0000, next FETCH; else -> ALUWB.
REQ-020 EXEC and ADDIEX register O into ovf_q at the clock edge leaving the state; O forced 0 for AND/OR/NOR/SLT.
REQ-021 ALUWB: RegDst=1, MemtoReg=0, RegWrite=!ovf_q, ovf_exc=ovf_q; -> FETCH.
REQ-022 MEMADR: ULAsrcA=1, ULAsrcB=10, ULAopcode=ADD; lw -> MEMRD, sw -> MEMWR.
REQ-023 MEMRD: MemRead=1, IorD=1; -> MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; -> FETCH.
REQ-024 MEMWR: MemWrite=1, IorD=1; -> FETCH.
REQ-025 BRANCH: ULAsrcA=1, ULAsrcB=00, ULAopcode=SUB, PCsrc=01, PCwrite=Z; -> FETCH.
REQ-026 ADDIEX: ULAsrcA=1, ULAsrcB=10, ULAopcode=ADD; -> ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=!ovf_q, ovf_exc=ovf_q; -> FETCH.
REQ-027 JUMP: PCsrc=10, PCwrite=1; -> FETCH.
REQ-028 Outputs are Moore-decoded from state (except PCwrite in BRANCH, qualified by Z); any strobe not listed for a state is 0; ULAopcode defaults to ADD.
REQ-029 Latency FETCH-to-FETCH: R-type/addi/sw 4 cycles, lw 5, beq/j 3, illegal 2.
REQ-030 Unreachable state encodings -> FETCH next cycle with all strobes 0.

Reset
REQ-031 rst=1 at a clk edge: state=FETCH, ovf_q=0, regardless of current state (mid-instruction abandoned, no writeback).
REQ-032 While rst=1 all write strobes (PCwrite, IRwrite, MemWrite, RegWrite) and pulses (ovf_exc, illegal) are 0; first FETCH executes on the first edge after rst falls.

Structure
REQ-033 Shared package holds: state enum, opcode constants, funct constants, ULAopcode constants (shared with ULA), ULAsrcB/PCsrc encodings.
REQ-034 One sub-module decod_ula: combinational funct->ULAopcode plus illegal-funct flag, used in EXEC.

Verification
REQ-035 add (funct 100000), A=7FFFFFFF, B=1 -> EXEC ULAopcode=0010, O=1, ALUWB RegWrite=0, ovf_exc=1 one cycle.
REQ-036 beq with A=B=5 (Z=1) -> BRANCH PCwrite=1, PCsrc=01; with A=5,B=6 -> PCwrite=0; both return to FETCH after 3 cycles.
REQ-037 lw sequence -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; MemRead=1 IorD=1 in MEMRD; RegWrite=1 MemtoReg=1 only in MEMWB.
REQ-038 opcode 111111 -> illegal=1 in DECODE, FETCH next, no write strobe asserted.
REQ-039 rst=1 asserted in MEMWR of sw -> MemWrite=0 that cycle, state FETCH after edge, ovf_q=0.
REQ-040 slt (funct 101010) and nor (100111) -> ULAopcode 0111 and 1100 in EXEC, RegDst=1 RegWrite=1 in ALUWB.

Source files
------------

// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, instruction fields,
// ULA operation codes and the datapath mux selects.
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Same codes the ULA decodes.
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;
  localparam logic [3:0] ULA_NOR = 4'b1100;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/controle_multiciclo_decod_ula.sv
// R-type funct decoder: ULA operation, unsupported-funct flag, and whether the
// operation can signal arithmetic overflow (only ADD/SUB).
module decod_ula
  import controle_multiciclo_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] ula_op,
  output logic       funct_ilegal,
  output logic       ovf_en
);

  always_comb begin
    ula_op       = ULA_AND;
    funct_ilegal = 1'b0;
    ovf_en       = 1'b0;
    case (funct)
      FN_ADD:  begin ula_op = ULA_ADD; ovf_en = 1'b1; end
      FN_SUB:  begin ula_op = ULA_SUB; ovf_en = 1'b1; end
      FN_AND:  ula_op = ULA_AND;
      FN_OR:   ula_op = ULA_OR;
      FN_NOR:  ula_op = ULA_NOR;
      FN_SLT:  ula_op = ULA_SLT;
      default: funct_ilegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset control FSM: Moore-decoded datapath controls, with the
// branch PC load qualified by Z and all write strobes/pulses held low during reset.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       Z,
  input  logic       O,
  output logic [3:0] ULAopcode,
  output logic       ULAsrcA,
  output logic [1:0] ULAsrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRwrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCwrite,
  output logic [1:0] PCsrc,
  output logic       ovf_exc,
  output logic       illegal
);

  state_t     state, next_state;
  logic       ovf_q;
  logic [3:0] dec_op;
  logic       funct_ilegal;
  logic       ovf_en;

  decod_ula u_decod_ula (
    .funct        (funct),
    .ula_op       (dec_op),
    .funct_ilegal (funct_ilegal),
    .ovf_en       (ovf_en)
  );

  // ovf_q only changes when leaving EXEC/ADDIEX so the writeback state sees it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      ovf_q <= 1'b0;
    end else begin
      state <= next_state;
      if (state == EXEC)
        ovf_q <= O & ovf_en;
      else if (state == ADDIEX)
        ovf_q <= O;
    end
  end

  always_comb begin
    next_state = FETCH;
    ULAopcode  = ULA_ADD;
    ULAsrcA    = 1'b0;
    ULAsrcB    = SRCB_REG;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRwrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    PCwrite    = 1'b0;
    PCsrc      = PCSRC_ULA;
    ovf_exc    = 1'b0;
    illegal    = 1'b0;
    case (state)
      FETCH: begin
        MemRead    = 1'b1;
        IRwrite    = 1'b1;
        ULAsrcB    = SRCB_FOUR;
        PCwrite    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        ULAsrcB = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:     next_state = EXEC;
          OP_LW, OP_SW: next_state = MEMADR;
          OP_BEQ:       next_state = BRANCH;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JUMP;
          default:      illegal    = 1'b1;
        endcase
      end
      EXEC: begin
        ULAsrcA   = 1'b1;
        ULAopcode = dec_op;
        if (funct_ilegal) illegal = 1'b1;
        else              next_state = ALUWB;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = ~ovf_q;
        ovf_exc  = ovf_q;
      end
      MEMADR: begin
        ULAsrcA = 1'b1;
        ULAsrcB = SRCB_IMM;
        if (opcode == OP_LW)      next_state = MEMRD;
        else if (opcode == OP_SW) next_state = MEMWR;
      end
      MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      BRANCH: begin
        ULAsrcA   = 1'b1;
        ULAopcode = ULA_SUB;
        PCsrc     = PCSRC_ALUOUT;
        PCwrite   = Z;
      end
      ADDIEX: begin
        ULAsrcA    = 1'b1;
        ULAsrcB    = SRCB_IMM;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = ~ovf_q;
        ovf_exc  = ovf_q;
      end
      JUMP: begin
        PCsrc   = PCSRC_JUMP;
        PCwrite = 1'b1;
      end
      default: next_state = FETCH;
    endcase
    if (rst) begin
      PCwrite  = 1'b0;
      IRwrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      ovf_exc  = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: walks each instruction class state by state
// and compares the state and full control word against hand-computed values.
module tb_controle_multiciclo;
  import controle_multiciclo_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode, funct;
  logic       Z, O;
  logic [3:0] ULAopcode;
  logic       ULAsrcA;
  logic [1:0] ULAsrcB;
  logic       IorD, MemRead, MemWrite, IRwrite;
  logic       RegDst, MemtoReg, RegWrite, PCwrite;
  logic [1:0] PCsrc;
  logic       ovf_exc, illegal;

  int checks   = 0;
  int failures = 0;

  controle_multiciclo dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .Z(Z), .O(O),
    .ULAopcode(ULAopcode), .ULAsrcA(ULAsrcA), .ULAsrcB(ULAsrcB),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRwrite(IRwrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .PCwrite(PCwrite), .PCsrc(PCsrc), .ovf_exc(ovf_exc), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [18:0] ctl;
  assign ctl = {ULAopcode, ULAsrcA, ULAsrcB, IorD, MemRead, MemWrite, IRwrite,
                RegDst, MemtoReg, RegWrite, PCwrite, PCsrc, ovf_exc, illegal};

  // Packs named control fields in the same order as ctl.
  function automatic logic [18:0] cw(input logic [3:0] op, input logic a, input logic [1:0] b,
                                     input logic iord, input logic mr, input logic mw,
                                     input logic irw, input logic rdst, input logic m2r,
                                     input logic rw, input logic pcw, input logic [1:0] pcs,
                                     input logic ovf, input logic ill);
    return {op, a, b, iord, mr, mw, irw, rdst, m2r, rw, pcw, pcs, ovf, ill};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_st(input string tag, input state_t s, input logic [18:0] w);
    chk({tag, "_state"}, 32'(dut.state), 32'(s));
    chk({tag, "_ctl"}, 32'(ctl), 32'(w));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [18:0] w_fetch, w_decode;

  initial begin
    w_fetch  = cw(4'b0010, 0, 2'b01, 0, 1, 0, 1, 0, 0, 0, 1, 2'b00, 0, 0);
    w_decode = cw(4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    rst = 1'b1; opcode = 6'b0; funct = 6'b0; Z = 1'b0; O = 1'b0;

    // Reset: FETCH held, MemRead visible but IRwrite/PCwrite suppressed.
    tick(); tick();
    expect_st("rst", FETCH, cw(4'b0010, 0, 2'b01, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    chk("rst_ovf_q", 32'(dut.ovf_q), 32'd0);
    rst = 1'b0; #1;
    expect_st("fetch0", FETCH, w_fetch);

    // add with overflow: writeback suppressed, one-cycle ovf_exc.
    opcode = OP_RTYPE; funct = FN_ADD;
    tick(); expect_st("add_dec", DECODE, w_decode);
    tick(); O = 1'b1; expect_st("add_exec", EXEC, cw(4'b0010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick(); O = 1'b0; expect_st("add_wb", ALUWB, cw(4'b0010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 1, 0));
    tick(); expect_st("add_ret", FETCH, w_fetch);

    // and with O=1: overflow ignored for logical ops.
    funct = FN_AND;
    tick(); tick(); O = 1'b1;
    expect_st("and_exec", EXEC, cw(4'b0000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick(); O = 1'b0;
    expect_st("and_wb", ALUWB, cw(4'b0010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0));
    tick(); expect_st("and_ret", FETCH, w_fetch);

    // slt and nor.
    funct = FN_SLT;
    tick(); tick();
    expect_st("slt_exec", EXEC, cw(4'b0111, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick(); expect_st("slt_wb", ALUWB, cw(4'b0010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0));
    tick(); funct = FN_NOR;
    tick(); tick();
    expect_st("nor_exec", EXEC, cw(4'b1100, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick(); expect_st("nor_wb", ALUWB, cw(4'b0010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 0, 0));
    tick(); expect_st("nor_ret", FETCH, w_fetch);

    // Unsupported funct: illegal in EXEC with ULAopcode 0000, then FETCH.
    funct = 6'b111111;
    tick(); tick();
    expect_st("badfn_exec", EXEC, cw(4'b0000, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
    tick(); expect_st("badfn_ret", FETCH, w_fetch);

    // beq taken (A=B=5, Z=1) and not taken (A=5, B=6, Z=0).
    opcode = OP_BEQ;
    tick(); expect_st("beq1_dec", DECODE, w_decode);
    tick(); Z = 1'b1; #1;
    expect_st("beq1_br", BRANCH, cw(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0));
    tick(); Z = 1'b0; expect_st("beq1_ret", FETCH, w_fetch);
    tick(); tick(); #1;
    expect_st("beq0_br", BRANCH, cw(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0));
    tick(); expect_st("beq0_ret", FETCH, w_fetch);

    // lw: five states.
    opcode = OP_LW;
    tick(); expect_st("lw_dec", DECODE, w_decode);
    tick(); expect_st("lw_adr", MEMADR, cw(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick(); expect_st("lw_rd", MEMRD, cw(4'b0010, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick(); expect_st("lw_wb", MEMWB, cw(4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0));
    tick(); expect_st("lw_ret", FETCH, w_fetch);

    // Illegal opcode: flagged in DECODE, no write strobes, back to FETCH.
    opcode = 6'b111111;
    tick(); expect_st("badop_dec", DECODE, cw(4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1));
    tick(); expect_st("badop_ret", FETCH, w_fetch);

    // addi with overflow.
    opcode = OP_ADDI;
    tick(); tick(); O = 1'b1;
    expect_st("addi_ex", ADDIEX, cw(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick(); O = 1'b0;
    expect_st("addi_wb", ADDIWB, cw(4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
    tick(); expect_st("addi_ret", FETCH, w_fetch);

    // j.
    opcode = OP_J;
    tick(); tick();
    expect_st("j_jump", JUMP, cw(4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0));
    tick(); expect_st("j_ret", FETCH, w_fetch);

    // Reset during ALUWB of an overflowing add: ovf_exc masked, ovf_q cleared.
    opcode = OP_RTYPE; funct = FN_ADD;
    tick(); tick(); O = 1'b1;
    tick(); O = 1'b0;
    chk("rstwb_ovf_q_set", 32'(dut.ovf_q), 32'd1);
    rst = 1'b1; #1;
    expect_st("rstwb", ALUWB, cw(4'b0010, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 0, 0));
    tick();
    chk("rstwb_after_state", 32'(dut.state), 32'(FETCH));
    chk("rstwb_after_ovf_q", 32'(dut.ovf_q), 32'd0);
    rst = 1'b0; #1;

    // sw with reset asserted in MEMWR.
    opcode = OP_SW;
    tick(); tick(); expect_st("sw_adr", MEMADR, cw(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick(); expect_st("sw_wr", MEMWR, cw(4'b0010, 0, 2'b00, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    rst = 1'b1; #1;
    expect_st("sw_rst", MEMWR, cw(4'b0010, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    tick();
    chk("sw_rst_state", 32'(dut.state), 32'(FETCH));
    chk("sw_rst_ovf_q", 32'(dut.ovf_q), 32'd0);
    rst = 1'b0; #1;
    expect_st("sw_rst_fetch", FETCH, w_fetch);
    tick(); expect_st("sw_rst_dec", DECODE, w_decode);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
